// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch core: digit width, BCD limits and FSM state encodings.
package stopwatch_pkg;

   localparam int unsigned DIGIT_W      = 5;
   localparam int unsigned SEC_TENS_MAX = 5;
   localparam int unsigned DIG_MAX      = 9;
   localparam int unsigned SEC_MAX      = SEC_TENS_MAX * 10 + DIG_MAX;

   typedef logic [1:0] state_t;

   localparam state_t ST_PAUSED = 2'd0;
   localparam state_t ST_RUN    = 2'd1;
   localparam state_t ST_ADJUST = 2'd2;

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up-counter that wraps from MAX to 00; carry_out flags the wrapping increment.
module bcd_pair_counter #(
   parameter int unsigned DIGIT_W = 5,
   parameter int unsigned MAX     = 59
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               clr,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               carry_out
);
   import stopwatch_pkg::*;

   localparam logic [DIGIT_W-1:0] MaxTens = DIGIT_W'(MAX / 10);
   localparam logic [DIGIT_W-1:0] MaxOnes = DIGIT_W'(MAX % 10);
   localparam logic [DIGIT_W-1:0] DigMax  = DIGIT_W'(DIG_MAX);

   logic [DIGIT_W-1:0] tens_q, tens_d;
   logic [DIGIT_W-1:0] ones_q, ones_d;
   logic               at_max;

   always_comb begin
      tens_d    = tens_q;
      ones_d    = ones_q;
      at_max    = (tens_q == MaxTens) && (ones_q == MaxOnes);
      carry_out = inc && at_max;
      if (clr) begin
         tens_d = '0;
         ones_d = '0;
      end else if (inc) begin
         if (at_max) begin
            tens_d = '0;
            ones_d = '0;
         end else if (ones_q == DigMax) begin
            ones_d = '0;
            tens_d = tens_q + 1'b1;
         end else begin
            ones_d = ones_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch core: RUN/PAUSED/ADJUST FSM, carry gating and wrap pulse.
// Optional lap freeze of the digit outputs when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
   parameter int unsigned DIGIT_W = stopwatch_pkg::DIGIT_W,
   parameter int unsigned MAX_MIN = 59
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_1hz,
   input  logic               tick_adj,
   input  logic               pause,
   input  logic               adj,
   input  logic               sel,
`ifdef STOPWATCH_LAP_EN
   input  logic               lap,
`endif
   output logic [DIGIT_W-1:0] min_l,
   output logic [DIGIT_W-1:0] min_r,
   output logic [DIGIT_W-1:0] sec_l,
   output logic [DIGIT_W-1:0] sec_r,
   output logic               running,
   output logic               wrap
);
   import stopwatch_pkg::*;

   state_t state_q, state_d;
   logic   running_q, running_d;
   logic   wrap_q, wrap_d;

   logic               run_tick, adj_tick;
   logic               sec_inc, min_inc, sec_carry, min_carry;
   logic [DIGIT_W-1:0] sec_t, sec_o, min_t, min_o;

   // Seconds carry into minutes only while running; adjust wraps each field on its own.
   assign run_tick = (state_q == ST_RUN) && tick_1hz;
   assign adj_tick = (state_q == ST_ADJUST) && tick_adj;
   assign sec_inc  = run_tick || (adj_tick && !sel);
   assign min_inc  = (run_tick && sec_carry) || (adj_tick && sel);

   bcd_pair_counter #(
      .DIGIT_W (DIGIT_W),
      .MAX     (SEC_MAX)
   ) u_sec (
      .clk       (clk),
      .rst       (rst),
      .inc       (sec_inc),
      .clr       (1'b0),
      .tens      (sec_t),
      .ones      (sec_o),
      .carry_out (sec_carry)
   );

   bcd_pair_counter #(
      .DIGIT_W (DIGIT_W),
      .MAX     (MAX_MIN)
   ) u_min (
      .clk       (clk),
      .rst       (rst),
      .inc       (min_inc),
      .clr       (1'b0),
      .tens      (min_t),
      .ones      (min_o),
      .carry_out (min_carry)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PAUSED: begin
            if (adj)        state_d = ST_ADJUST;
            else if (pause) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (adj)        state_d = ST_ADJUST;
            else if (pause) state_d = ST_PAUSED;
         end
         ST_ADJUST: begin
            if (!adj)       state_d = ST_PAUSED;
         end
         default:           state_d = ST_PAUSED;
      endcase
      running_d = (state_d == ST_RUN);
      wrap_d    = run_tick && sec_carry && min_carry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PAUSED;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   assign running = running_q;
   assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
   logic                   freeze_q, freeze_d;
   logic [4*DIGIT_W-1:0]   snap_q, snap_d;
   logic [4*DIGIT_W-1:0]   live;

   assign live = {min_t, min_o, sec_t, sec_o};

   // Snapshot captures the time currently on display, before any same-cycle tick.
   always_comb begin
      freeze_d = freeze_q;
      snap_d   = snap_q;
      if (state_d != ST_RUN) begin
         freeze_d = 1'b0;
      end else if (lap && (state_q == ST_RUN)) begin
         freeze_d = !freeze_q;
         if (!freeze_q) snap_d = live;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         freeze_q <= 1'b0;
         snap_q   <= '0;
      end else begin
         freeze_q <= freeze_d;
         snap_q   <= snap_d;
      end
   end

   assign {min_l, min_r, sec_l, sec_r} = freeze_q ? snap_q : live;
`else
   assign {min_l, min_r, sec_l, sec_r} = {min_t, min_o, sec_t, sec_o};
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core; lap checks build when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;

   localparam int unsigned DW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick_1hz = 1'b0;
   logic          tick_adj = 1'b0;
   logic          pause = 1'b0;
   logic          adj = 1'b0;
   logic          sel = 1'b0;
`ifdef STOPWATCH_LAP_EN
   logic          lap = 1'b0;
`endif
   logic [DW-1:0] min_l, min_r, sec_l, sec_r;
   logic          running, wrap;

   int n_cmp = 0;
   int n_bad = 0;

   stopwatch_core #(
      .DIGIT_W (DW),
      .MAX_MIN (59)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_1hz (tick_1hz),
      .tick_adj (tick_adj),
      .pause    (pause),
      .adj      (adj),
      .sel      (sel),
`ifdef STOPWATCH_LAP_EN
      .lap      (lap),
`endif
      .min_l    (min_l),
      .min_r    (min_r),
      .sec_l    (sec_l),
      .sec_r    (sec_r),
      .running  (running),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   function automatic int disp();
      return int'(min_l) * 1000 + int'(min_r) * 100 + int'(sec_l) * 10 + int'(sec_r);
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1;
         step();
         tick_1hz = 1'b0;
      end
   endtask

   task automatic pulse_adj(input int n);
      for (int i = 0; i < n; i++) begin
         tick_adj = 1'b1;
         step();
         tick_adj = 1'b0;
      end
   endtask

   task automatic pulse_pause();
      pause = 1'b1;
      step();
      pause = 1'b0;
   endtask

   initial begin
      int wrap_seen;

      // Reset state
      step();
      step();
      chk("rst_time", disp(), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_wrap", int'(wrap), 0);
      rst = 1'b0;
      step();

      // 1: run 61 seconds
      pulse_pause();
      chk("t1_running", int'(running), 1);
      wrap_seen = 0;
      for (int i = 0; i < 61; i++) begin
         pulse_tick(1);
         if (wrap) wrap_seen++;
      end
      chk("t1_wrap_none", wrap_seen, 0);
      chk("t1_time", disp(), 101);
      chk("t1_running_end", int'(running), 1);

      // 2: preload 59:58 and wrap
      adj = 1'b1;
      step();
      chk("t2_adj_running", int'(running), 0);
      sel = 1'b1;
      pulse_adj(58);
      sel = 1'b0;
      pulse_adj(57);
      adj = 1'b0;
      step();
      chk("t2_preload", disp(), 5958);
      pulse_pause();
      pulse_tick(1);
      chk("t2_5959", disp(), 5959);
      chk("t2_wrap_pre", int'(wrap), 0);
      pulse_tick(1);
      chk("t2_0000", disp(), 0);
      chk("t2_wrap_hi", int'(wrap), 1);
      step();
      chk("t2_wrap_lo", int'(wrap), 0);
      pulse_pause();
      chk("t2_paused", int'(running), 0);

      // 3: adjust field wraps, no carry
      adj = 1'b1;
      step();
      sel = 1'b0;
      pulse_adj(58);
      chk("t3_0058", disp(), 58);
      pulse_adj(3);
      chk("t3_sec_wrap", disp(), 1);
      pulse_tick(1);
      chk("t3_tick1hz_ignored", disp(), 1);
      sel = 1'b1;
      pulse_adj(59);
      chk("t3_5901", disp(), 5901);
      pulse_adj(1);
      chk("t3_min_wrap", disp(), 1);
      chk("t3_no_wrap_pulse", int'(wrap), 0);
      adj = 1'b0;
      step();
      pulse_adj(1);
      chk("t3_tickadj_ignored", disp(), 1);

      // 4: simultaneous events
      pulse_pause();
      pulse_tick(6);
      chk("t4_0007", disp(), 7);
      tick_1hz = 1'b1;
      pause = 1'b1;
      step();
      tick_1hz = 1'b0;
      pause = 1'b0;
      chk("t4_run_tp_time", disp(), 8);
      chk("t4_run_tp_running", int'(running), 0);
      tick_1hz = 1'b1;
      pause = 1'b1;
      step();
      tick_1hz = 1'b0;
      pause = 1'b0;
      chk("t4_pau_tp_time", disp(), 8);
      chk("t4_pau_tp_running", int'(running), 1);
      adj = 1'b1;
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      chk("t4_adj_tick_time", disp(), 9);
      chk("t4_adj_tick_running", int'(running), 0);
      adj = 1'b0;
      step();
      pulse_pause();
      chk("t4_adj_exit_paused", int'(running), 1);
      pulse_pause();

      // 5: async reset mid-count at 12:34
      adj = 1'b1;
      step();
      sel = 1'b1;
      pulse_adj(12);
      sel = 1'b0;
      pulse_adj(25);
      adj = 1'b0;
      step();
      pulse_pause();
      chk("t5_1234", disp(), 1234);
      chk("t5_running", int'(running), 1);
      tick_1hz = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      chk("t5_async_time", disp(), 0);
      chk("t5_async_running", int'(running), 0);
      tick_1hz = 1'b0;
      step();
      rst = 1'b0;
      pulse_tick(1);
      chk("t5_paused_after", disp(), 0);

`ifdef STOPWATCH_LAP_EN
      // 6: lap freeze
      pulse_pause();
      pulse_tick(5);
      lap = 1'b1;
      step();
      lap = 1'b0;
      chk("t6_lap_0005", disp(), 5);
      pulse_tick(10);
      chk("t6_frozen", disp(), 5);
      lap = 1'b1;
      step();
      lap = 1'b0;
      chk("t6_release", disp(), 15);
      lap = 1'b1;
      step();
      lap = 1'b0;
      pulse_tick(1);
      chk("t6_frozen2", disp(), 15);
      pulse_pause();
      chk("t6_pause_release", disp(), 16);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
